data_mem_stage: RTL and testbench

DATA_MEM_STAGE -- requirements
Module: data_mem_stage

---
 rtl/mem_pkg.sv | 59 +++++
 rtl/data_mem_stage_load_extend.sv | 30 +++
 rtl/data_mem_stage.sv | 143 ++++++++++++++
 tb/tb_data_mem_stage.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared types for the data memory stage.
// Holds funct3 codes, FSM state type, access sizes and the request bundle.
package mem_pkg;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_NOP = 3'b111;

  localparam logic [3:0] SZ_B = 4'd1;
  localparam logic [3:0] SZ_H = 4'd2;
  localparam logic [3:0] SZ_W = 4'd4;
  localparam logic [3:0] SZ_D = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_DONE
  } state_t;

  typedef struct packed {
    logic        st;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] data;
  } mem_req_t;

  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    logic [3:0] n;
    n = SZ_B;
    unique case (sz)
      2'd0: n = SZ_B;
      2'd1: n = SZ_H;
      2'd2: n = SZ_W;
      2'd3: n = SZ_D;
      default: n = SZ_B;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] lane_mask(input logic [1:0] sz);
    logic [7:0] m;
    m = 8'h01;
    unique case (sz)
      2'd0: m = 8'h01;
      2'd1: m = 8'h03;
      2'd2: m = 8'h0f;
      2'd3: m = 8'hff;
      default: m = 8'h01;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/data_mem_stage_load_extend.sv
// load_extend: selects the addressed bytes of a 64-bit word and extends them.
// Ports: word (array word), lane (byte offset), funct3 (size/sign), data (result).
module load_extend
  import mem_pkg::*;
(
  input  logic [63:0] word,
  input  logic [2:0]  lane,
  input  logic [2:0]  funct3,
  output logic [63:0] data
);

  logic [63:0] sh;

  assign sh = word >> {lane, 3'b000};

  always_comb begin
    data = sh;
    unique case (funct3)
      F3_B:    data = {{56{sh[7]}}, sh[7:0]};
      F3_H:    data = {{48{sh[15]}}, sh[15:0]};
      F3_W:    data = {{32{sh[31]}}, sh[31:0]};
      F3_D:    data = sh;
      F3_BU:   data = {56'd0, sh[7:0]};
      F3_HU:   data = {48'd0, sh[15:0]};
      F3_WU:   data = {32'd0, sh[31:0]};
      default: data = sh;
    endcase
  end

endmodule

// File: rtl/data_mem_stage.sv
// data_mem_stage: multi-cycle load/store unit over a DEPTH x 64-bit array.
// Inputs MemRead/MemWrite/funct3/ALUResult/ReadData2 are sampled in IDLE;
// outputs ReadData (registered), MemBusy, MemDone and MisalignFault pulses.
// Define MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning.
module data_mem_stage
  import mem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [63:0] ALUResult,
  input  logic [63:0] ReadData2,
  output logic [63:0] ReadData,
  output logic        MemBusy,
  output logic        MemDone,
  output logic        MisalignFault
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WAIT_CYCLES + 2);

  state_t        state, nxt;
  logic [CW-1:0] cnt;
  mem_req_t      req;
  logic [63:0]   mem [DEPTH];
  logic          req_in;
  logic          done_q;

  logic [3:0]    nbytes;
  logic [2:0]    lowm;
  logic [2:0]    lane;
  logic [AW-1:0] idx;
  logic          nop;
  logic          fault;
  logic          do_acc;
  logic [7:0]    bmask;
  logic [63:0]   wdata;
  logic [63:0]   ld_data;
  logic          unused_hi;

  assign req_in  = MemRead | MemWrite;
  assign MemBusy = (state != S_IDLE) | req_in;
  assign MemDone = done_q;

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: begin
        if (req_in)
          nxt = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
      end
      S_WAIT: begin
        if (cnt == CW'(1))
          nxt = S_ACCESS;
      end
      S_ACCESS: nxt = S_DONE;
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      done_q   <= 1'b0;
      ReadData <= '0;
    end else begin
      state  <= nxt;
      done_q <= (state == S_ACCESS);
      if (state == S_IDLE && req_in)
        cnt <= CW'(WAIT_CYCLES);
      else if (state == S_WAIT)
        cnt <= cnt - CW'(1);
      if (do_acc && !req.st)
        ReadData <= ld_data;
    end
  end

  // Both request bits high is a store.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && req_in) begin
      req.st   <= MemWrite;
      req.f3   <= funct3;
      req.addr <= ALUResult;
      req.data <= ReadData2;
    end
  end

  assign unused_hi = ^req.addr[63:AW+3];

  assign nbytes = size_bytes(req.f3[1:0]);
  assign lowm   = 3'(nbytes - 4'd1);
  assign nop    = (req.f3 == F3_NOP);
  assign idx    = req.addr[3 +: AW];

`ifdef MISALIGN_TRAP_EN
  logic fault_q;

  assign fault = ~nop & (|(req.addr[2:0] & lowm));
  assign lane  = req.addr[2:0];

  always_ff @(posedge clk) begin
    if (reset)
      fault_q <= 1'b0;
    else
      fault_q <= (state == S_ACCESS) & fault;
  end

  assign MisalignFault = fault_q;
`else
  assign fault         = 1'b0;
  assign lane          = req.addr[2:0] & ~lowm;
  assign MisalignFault = 1'b0;
`endif

  assign do_acc = (state == S_ACCESS) & ~nop & ~fault;
  assign bmask  = lane_mask(req.f3[1:0]) << lane;
  assign wdata  = req.data << {lane, 3'b000};

  // Reset in the access cycle must still suppress the store.
  always_ff @(posedge clk) begin
    if (do_acc && req.st && !reset) begin
      for (int i = 0; i < 8; i++) begin
        if (bmask[i])
          mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  load_extend u_ext (
    .word   (mem[idx]),
    .lane   (lane),
    .funct3 (req.f3),
    .data   (ld_data)
  );

endmodule

// File: tb/tb_data_mem_stage.sv
// tb_data_mem_stage: table vectors, reset abort sequence and random
// traffic checked against a byte-array reference model.
module tb_data_mem_stage;

  localparam int DEPTH       = 256;
  localparam int WAIT_CYCLES = 1;
  localparam int LAT         = WAIT_CYCLES + 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [63:0] ALUResult;
  logic [63:0] ReadData2;
  logic [63:0] ReadData;
  logic        MemBusy;
  logic        MemDone;
  logic        MisalignFault;

  int tests = 0;
  int fails = 0;

  byte unsigned ref_mem [DEPTH*8];
  logic [63:0]  ref_rd;

  typedef struct {
    string       nm;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] data;
    logic [63:0] exp_rd;
    logic        exp_f;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  data_mem_stage #(
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .funct3        (funct3),
    .ALUResult     (ALUResult),
    .ReadData2     (ReadData2),
    .ReadData      (ReadData),
    .MemBusy       (MemBusy),
    .MemDone       (MemDone),
    .MisalignFault (MisalignFault)
  );

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference: byte-addressed array, addresses wrap modulo the array size.
  task automatic model(input logic rd, input logic wr,
                       input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] data,
                       output logic [63:0] erd, output logic ef);
    int unsigned     n;
    longint unsigned a;
    logic [63:0]     v;
    n  = 1 << f3[1:0];
    a  = addr % 64'(DEPTH*8);
    ef = 1'b0;
    if (f3 != 3'b111) begin
      if ((a % n) != 0) begin
`ifdef MISALIGN_TRAP_EN
        ef = 1'b1;
`else
        a = a - (a % n);
`endif
      end
      if (!ef && wr) begin
        for (int k = 0; k < int'(n); k++)
          ref_mem[a+k] = data[8*k +: 8];
      end else if (!ef && rd) begin
        v = '0;
        for (int k = 0; k < int'(n); k++)
          v = v | (64'(ref_mem[a+k]) << (8*k));
        if (!f3[2] && n < 8 && v[8*n-1])
          v = v | (~64'd0 << (8*n));
        ref_rd = v;
      end
    end
    erd = ref_rd;
  endtask

  task automatic idle_in();
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    funct3    = 3'b000;
    ALUResult = '0;
    ReadData2 = '0;
  endtask

  task automatic do_op(input string nm, input logic rd, input logic wr,
                       input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] data, input bit junk,
                       output logic [63:0] got, output logic gotf);
    logic [63:0] erd;
    logic        ef;
    int          lat;
    bit          done;
    model(rd, wr, f3, addr, data, erd, ef);
    @(negedge clk);
    MemRead   = rd;
    MemWrite  = wr;
    funct3    = f3;
    ALUResult = addr;
    ReadData2 = data;
    #1 chk({nm, "_busy_req"}, 64'(MemBusy), 64'd1);
    lat  = 0;
    done = 1'b0;
    got  = 'x;
    gotf = 1'bx;
    for (int n = 1; n <= 40 && !done; n++) begin
      @(negedge clk);
      if (MemDone === 1'b1) begin
        done = 1'b1;
        lat  = n;
        got  = ReadData;
        gotf = MisalignFault;
        chk({nm, "_busy_done"}, 64'(MemBusy), 64'd1);
        idle_in();
      end else begin
        chk({nm, "_busy_fault"}, {62'd0, MemBusy, MisalignFault},
            64'd2);
        if (junk) begin
          MemRead   = 1'($urandom);
          MemWrite  = 1'($urandom);
          funct3    = 3'($urandom);
          ALUResult = {$urandom, $urandom};
          ReadData2 = {$urandom, $urandom};
        end else begin
          idle_in();
        end
      end
    end
    idle_in();
    chk({nm, "_done_seen"}, 64'(done), 64'd1);
    chk({nm, "_latency"}, 64'(lat), 64'(LAT));
    chk({nm, "_rdata"}, got, erd);
    chk({nm, "_fault"}, 64'(gotf), 64'(ef));
    @(negedge clk);
    chk({nm, "_pulse_end"}, {62'd0, MemDone, MemBusy}, 64'd0);
  endtask

  task automatic add(input string nm, input logic rd, input logic wr,
                     input logic [2:0] f3, input logic [63:0] addr,
                     input logic [63:0] data, input logic [63:0] exp_rd,
                     input logic exp_f);
    vec_t v;
    v.nm     = nm;
    v.rd     = rd;
    v.wr     = wr;
    v.f3     = f3;
    v.addr   = addr;
    v.data   = data;
    v.exp_rd = exp_rd;
    v.exp_f  = exp_f;
    tbl.push_back(v);
  endtask

  initial begin
    logic [63:0] g;
    logic        gf;
    logic [63:0] lh_exp;
    logic        lh_f;
    int          sel;
    logic [63:0] ra;

    ref_rd = '0;
    reset  = 1'b1;
    idle_in();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rdata", ReadData, 64'd0);
    chk("reset_flags", {61'd0, MemBusy, MemDone, MisalignFault}, 64'd0);
    reset = 1'b0;

    for (int w = 0; w < 16; w++)
      do_op("pre", 1'b0, 1'b1, 3'b011, 64'(w*8), {$urandom, $urandom},
            1'b0, g, gf);

`ifdef MISALIGN_TRAP_EN
    lh_exp = 64'h0000000080000000;
    lh_f   = 1'b1;
`else
    lh_exp = 64'h0000000000005566;
    lh_f   = 1'b0;
`endif

    add("sd40",   0, 1, 3'b011, 64'h40, 64'h1122334455667788,
        64'h0, 0);
    add("ld40",   1, 0, 3'b011, 64'h40, 64'h0,
        64'h1122334455667788, 0);
    add("sb41",   0, 1, 3'b000, 64'h41, 64'h123456789abcdeff,
        64'h1122334455667788, 0);
    add("lb41",   1, 0, 3'b000, 64'h41, 64'h0,
        64'hffffffffffffffff, 0);
    add("lbu41",  1, 0, 3'b100, 64'h41, 64'h0,
        64'h00000000000000ff, 0);
    add("ld40b",  1, 0, 3'b011, 64'h40, 64'h0,
        64'h112233445566ff88, 0);
    add("sw44",   0, 1, 3'b010, 64'h44, 64'hdeadbeef80000000,
        64'h112233445566ff88, 0);
    add("lw44",   1, 0, 3'b010, 64'h44, 64'h0,
        64'hffffffff80000000, 0);
    add("lwu44",  1, 0, 3'b110, 64'h44, 64'h0,
        64'h0000000080000000, 0);
    add("lh43",   1, 0, 3'b001, 64'h43, 64'h0, lh_exp, lh_f);
    add("nop_ld", 1, 0, 3'b111, 64'h40, 64'h0, lh_exp, 0);
    add("nop_st", 0, 1, 3'b111, 64'h40, 64'h0, lh_exp, 0);
    add("ld40c",  1, 0, 3'b011, 64'h40, 64'h0,
        64'h800000005566ff88, 0);
    add("sh_f3hu", 0, 1, 3'b101, 64'h40, 64'hffff1234,
        64'h800000005566ff88, 0);
    add("ld40d",  1, 0, 3'b011, 64'h40, 64'h0,
        64'h8000000055661234, 0);
    add("sd48",   0, 1, 3'b011, 64'h48, 64'h0123456789abcdef,
        64'h8000000055661234, 0);
    add("sd_wrap", 0, 1, 3'b011, 64'(DEPTH*8 + 'h50),
        64'hcafef00d12345678, 64'h8000000055661234, 0);
    add("ld_wrap", 1, 0, 3'b011, 64'h50, 64'h0,
        64'hcafef00d12345678, 0);
    add("rd_wr",  1, 1, 3'b011, 64'h58, 64'h0f1e2d3c4b5a6978,
        64'hcafef00d12345678, 0);
    add("ld58",   1, 0, 3'b011, 64'h58, 64'h0,
        64'h0f1e2d3c4b5a6978, 0);

    foreach (tbl[i]) begin
      do_op(tbl[i].nm, tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].addr,
            tbl[i].data, 1'b0, g, gf);
      chk({tbl[i].nm, "_vec_rd"}, g, tbl[i].exp_rd);
      chk({tbl[i].nm, "_vec_f"}, 64'(gf), 64'(tbl[i].exp_f));
    end

    // Store aborted by reset while waiting.
    @(negedge clk);
    MemWrite  = 1'b1;
    funct3    = 3'b011;
    ALUResult = 64'h48;
    ReadData2 = 64'hfeedfacefeedface;
    @(posedge clk);
    @(negedge clk);
    idle_in();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_rdata", ReadData, 64'd0);
    chk("abort_flags", {61'd0, MemBusy, MemDone, MisalignFault}, 64'd0);
    reset  = 1'b0;
    ref_rd = '0;
    do_op("ld48_after_abort", 1'b1, 1'b0, 3'b011, 64'h48, 64'h0,
          1'b0, g, gf);
    chk("ld48_prior", g, 64'h0123456789abcdef);

    for (int i = 0; i < 200; i++) begin
      sel = int'($urandom_range(1, 3));
      ra  = ({$urandom, $urandom} & ~64'(DEPTH*8 - 1)) |
            64'($urandom_range(0, 127));
      do_op("rnd", sel[0], sel[1], 3'($urandom_range(0, 7)), ra,
            {$urandom, $urandom}, 1'b1, g, gf);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
